// File: rtl/cci_hazard_tracker_if.sv
// cci_hazard_tracker_if
//   Bundles the CCI request/response observation taps and the hazard
//   reporting outputs of cci_hazard_tracker.
//
// Handshake: every strobe is valid-only. A channel carries a transaction
// on each rising clk edge where its *_valid bit is 1. There is no ready
// signal because the tracker only observes traffic and can never
// backpressure the AFU. Reporting outputs are registered and change only
// on clk edges or on reset.
//
// Signals (master = traffic source / observer, slave = tracker):
//   req_valid/req_is_wr [NUM_REQ]        request strobe / 1=write
//   req_addr  [NUM_REQ*CLADDR_WIDTH]     line address, ch0 in LSBs
//   req_mdata [NUM_REQ*MDATA_WIDTH]      request tag, ch0 in LSBs
//   rsp_valid [NUM_RSP]                  response strobe
//   rsp_mdata [NUM_RSP*MDATA_WIDTH]      response tag, ch0 in LSBs
//   hazard_valid/kind/addr               one-cycle hazard report
//   hazard_count/orphan_count            saturating statistics
//   occupancy/overflow                   table fill level, sticky drop flag
interface cci_hazard_tracker_if #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_RSP      = 3,
  parameter int TRACK_DEPTH  = 16,
  parameter int CLADDR_WIDTH = 32,
  parameter int MDATA_WIDTH  = 14,
  parameter int CNT_WIDTH    = 32
);
  localparam int OCC_WIDTH = $clog2(TRACK_DEPTH + 1);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_is_wr;
  logic [NUM_REQ*CLADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*MDATA_WIDTH-1:0]  req_mdata;
  logic [NUM_RSP-1:0]              rsp_valid;
  logic [NUM_RSP*MDATA_WIDTH-1:0]  rsp_mdata;

  logic                            hazard_valid;
  logic [1:0]                      hazard_kind;
  logic [CLADDR_WIDTH-1:0]         hazard_addr;
  logic [CNT_WIDTH-1:0]            hazard_count;
  logic [CNT_WIDTH-1:0]            orphan_count;
  logic [OCC_WIDTH-1:0]            occupancy;
  logic                            overflow;

  modport master (
    output req_valid, req_is_wr, req_addr, req_mdata, rsp_valid, rsp_mdata,
    input  hazard_valid, hazard_kind, hazard_addr, hazard_count,
           orphan_count, occupancy, overflow
  );

  modport slave (
    input  req_valid, req_is_wr, req_addr, req_mdata, rsp_valid, rsp_mdata,
    output hazard_valid, hazard_kind, hazard_addr, hazard_count,
           orphan_count, occupancy, overflow
  );
endinterface

// File: rtl/cci_hazard_tracker.sv
// cci_hazard_tracker
//   Passive CCI hazard tracker. Keeps outstanding requests in a fixed
//   TRACK_DEPTH-entry table, flags same-line hazards (RAW/WAR/WAW and
//   optionally RAR) and retires entries on mdata-matched responses.
//
// Ports:
//   clk     clock
//   resetb  asynchronous active-high reset (clears table and all outputs)
//   bus     cci_hazard_tracker_if.slave: request/response taps in,
//           hazard report, counters, occupancy, overflow out
//
// Build option:
//   CCI_HAZARD_RAR_EN  when defined, read-after-read same-line matches are
//                      reported as kind 3 and counted; otherwise ignored.
//
// Each cycle is evaluated as retire -> compare -> allocate in one
// combinational pass and committed on the clock edge.
module cci_hazard_tracker #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_RSP      = 3,
  parameter int TRACK_DEPTH  = 16,
  parameter int CLADDR_WIDTH = 32,
  parameter int MDATA_WIDTH  = 14,
  parameter int CNT_WIDTH    = 32
) (
  input logic                 clk,
  input logic                 resetb,
  cci_hazard_tracker_if.slave bus
);
  localparam int OCC_WIDTH = $clog2(TRACK_DEPTH + 1);

  localparam logic [1:0] KIND_RAW = 2'd0;
  localparam logic [1:0] KIND_WAR = 2'd1;
  localparam logic [1:0] KIND_WAW = 2'd2;
  localparam logic [1:0] KIND_RAR = 2'd3;

  // Severity ranking used to pick one kind when several entries match.
  localparam logic [2:0] SEV_NONE = 3'd0;
  localparam logic [2:0] SEV_RAR  = 3'd1;
  localparam logic [2:0] SEV_WAR  = 3'd2;
  localparam logic [2:0] SEV_WAW  = 3'd3;
  localparam logic [2:0] SEV_RAW  = 3'd4;

`ifdef CCI_HAZARD_RAR_EN
  localparam bit RAR_EN = 1'b1;
`else
  localparam bit RAR_EN = 1'b0;
`endif

  // Tracking table
  logic [TRACK_DEPTH-1:0]  ent_valid;
  logic [TRACK_DEPTH-1:0]  ent_wr;
  logic [CLADDR_WIDTH-1:0] ent_addr  [TRACK_DEPTH];
  logic [MDATA_WIDTH-1:0]  ent_mdata [TRACK_DEPTH];

  // Next-state table and per-cycle working values
  logic [TRACK_DEPTH-1:0]  surv;
  logic [TRACK_DEPTH-1:0]  nxt_valid;
  logic [TRACK_DEPTH-1:0]  nxt_wr;
  logic [CLADDR_WIDTH-1:0] nxt_addr  [TRACK_DEPTH];
  logic [MDATA_WIDTH-1:0]  nxt_mdata [TRACK_DEPTH];
  logic [2:0]              req_sev   [NUM_REQ];
  logic                    found;
  logic                    ovf_set;
  logic [CNT_WIDTH-1:0]    orphan_inc;
  logic [CNT_WIDTH-1:0]    hazard_inc;
  logic                    hz_valid_nxt;
  logic [1:0]              hz_kind_nxt;
  logic [CLADDR_WIDTH-1:0] hz_addr_nxt;
  logic [OCC_WIDTH-1:0]    occ_nxt;

  // Output registers
  logic                    hazard_valid_q;
  logic [1:0]              hazard_kind_q;
  logic [CLADDR_WIDTH-1:0] hazard_addr_q;
  logic [CNT_WIDTH-1:0]    hazard_count_q;
  logic [CNT_WIDTH-1:0]    orphan_count_q;
  logic [OCC_WIDTH-1:0]    occ_q;
  logic                    overflow_q;

  function automatic logic [2:0] sev_of(input logic older_wr, input logic newer_wr);
    logic [2:0] s;
    case ({older_wr, newer_wr})
      2'b10:   s = SEV_RAW;
      2'b11:   s = SEV_WAW;
      2'b01:   s = SEV_WAR;
      default: s = RAR_EN ? SEV_RAR : SEV_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] sev_to_kind(input logic [2:0] s);
    logic [1:0] k;
    case (s)
      SEV_RAW: k = KIND_RAW;
      SEV_WAW: k = KIND_WAW;
      SEV_WAR: k = KIND_WAR;
      default: k = KIND_RAR;
    endcase
    return k;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    surv         = ent_valid;
    nxt_wr       = ent_wr;
    nxt_addr     = ent_addr;
    nxt_mdata    = ent_mdata;
    found        = 1'b0;
    ovf_set      = 1'b0;
    orphan_inc   = '0;
    hazard_inc   = '0;
    hz_valid_nxt = 1'b0;
    hz_kind_nxt  = hazard_kind_q;
    hz_addr_nxt  = hazard_addr_q;
    occ_nxt      = '0;
    for (int c = 0; c < NUM_REQ; c++) req_sev[c] = SEV_NONE;

    // Retire: clearing surv as we go means a higher rsp channel cannot
    // claim an entry already taken by a lower one.
    for (int r = 0; r < NUM_RSP; r++) begin
      if (bus.rsp_valid[r]) begin
        found = 1'b0;
        for (int i = 0; i < TRACK_DEPTH; i++) begin
          if (!found && surv[i] &&
              ent_mdata[i] == bus.rsp_mdata[r*MDATA_WIDTH +: MDATA_WIDTH]) begin
            surv[i] = 1'b0;
            found   = 1'b1;
          end
        end
        if (!found) orphan_inc = orphan_inc + CNT_WIDTH'(1);
      end
    end

    // Compare against surviving entries and older same-cycle requests.
    for (int c = 0; c < NUM_REQ; c++) begin
      if (bus.req_valid[c]) begin
        for (int i = 0; i < TRACK_DEPTH; i++) begin
          if (surv[i] && ent_addr[i] == bus.req_addr[c*CLADDR_WIDTH +: CLADDR_WIDTH]) begin
            if (sev_of(ent_wr[i], bus.req_is_wr[c]) > req_sev[c])
              req_sev[c] = sev_of(ent_wr[i], bus.req_is_wr[c]);
          end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
          if (k < c && bus.req_valid[k] &&
              bus.req_addr[k*CLADDR_WIDTH +: CLADDR_WIDTH] ==
              bus.req_addr[c*CLADDR_WIDTH +: CLADDR_WIDTH]) begin
            if (sev_of(bus.req_is_wr[k], bus.req_is_wr[c]) > req_sev[c])
              req_sev[c] = sev_of(bus.req_is_wr[k], bus.req_is_wr[c]);
          end
        end
      end
    end

    // Report from the lowest hazarding channel; count every hazarding one.
    for (int c = 0; c < NUM_REQ; c++) begin
      if (req_sev[c] != SEV_NONE) begin
        hazard_inc = hazard_inc + CNT_WIDTH'(1);
        if (!hz_valid_nxt) begin
          hz_valid_nxt = 1'b1;
          hz_kind_nxt  = sev_to_kind(req_sev[c]);
          hz_addr_nxt  = bus.req_addr[c*CLADDR_WIDTH +: CLADDR_WIDTH];
        end
      end
    end

    // Allocate: entries freed by retire above are reusable this cycle.
    nxt_valid = surv;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (bus.req_valid[c]) begin
        found = 1'b0;
        for (int i = 0; i < TRACK_DEPTH; i++) begin
          if (!found && !nxt_valid[i]) begin
            nxt_valid[i] = 1'b1;
            nxt_wr[i]    = bus.req_is_wr[c];
            nxt_addr[i]  = bus.req_addr[c*CLADDR_WIDTH +: CLADDR_WIDTH];
            nxt_mdata[i] = bus.req_mdata[c*MDATA_WIDTH +: MDATA_WIDTH];
            found        = 1'b1;
          end
        end
        if (!found) ovf_set = 1'b1;
      end
    end

    for (int i = 0; i < TRACK_DEPTH; i++)
      occ_nxt = occ_nxt + OCC_WIDTH'(nxt_valid[i]);
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      ent_valid      <= '0;
      ent_wr         <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        ent_addr[i]  <= '0;
        ent_mdata[i] <= '0;
      end
      hazard_valid_q <= 1'b0;
      hazard_kind_q  <= '0;
      hazard_addr_q  <= '0;
      hazard_count_q <= '0;
      orphan_count_q <= '0;
      occ_q          <= '0;
      overflow_q     <= 1'b0;
    end else begin
      ent_valid      <= nxt_valid;
      ent_wr         <= nxt_wr;
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        ent_addr[i]  <= nxt_addr[i];
        ent_mdata[i] <= nxt_mdata[i];
      end
      hazard_valid_q <= hz_valid_nxt;
      hazard_kind_q  <= hz_kind_nxt;
      hazard_addr_q  <= hz_addr_nxt;
      hazard_count_q <= sat_add(hazard_count_q, hazard_inc);
      orphan_count_q <= sat_add(orphan_count_q, orphan_inc);
      occ_q          <= occ_nxt;
      overflow_q     <= overflow_q | ovf_set;
    end
  end

  assign bus.hazard_valid = hazard_valid_q;
  assign bus.hazard_kind  = hazard_kind_q;
  assign bus.hazard_addr  = hazard_addr_q;
  assign bus.hazard_count = hazard_count_q;
  assign bus.orphan_count = orphan_count_q;
  assign bus.occupancy    = occ_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_cci_hazard_tracker.sv
// tb_cci_hazard_tracker
//   Directed bench for cci_hazard_tracker with hand-computed expectations.
//   Honours CCI_HAZARD_RAR_EN when defined for both bench and design.
module tb_cci_hazard_tracker;
  localparam int NUM_REQ      = 2;
  localparam int NUM_RSP      = 3;
  localparam int TRACK_DEPTH  = 16;
  localparam int CLADDR_WIDTH = 32;
  localparam int MDATA_WIDTH  = 14;
  localparam int CNT_WIDTH    = 32;
`ifdef CCI_HAZARD_RAR_EN
  localparam int RAR_HITS = 1;
`else
  localparam int RAR_HITS = 0;
`endif

  logic clk;
  logic resetb;
  int   n_cmp;
  int   n_mis;
  int   exp_cnt;

  cci_hazard_tracker_if #(
    .NUM_REQ(NUM_REQ), .NUM_RSP(NUM_RSP), .TRACK_DEPTH(TRACK_DEPTH),
    .CLADDR_WIDTH(CLADDR_WIDTH), .MDATA_WIDTH(MDATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  cci_hazard_tracker #(
    .NUM_REQ(NUM_REQ), .NUM_RSP(NUM_RSP), .TRACK_DEPTH(TRACK_DEPTH),
    .CLADDR_WIDTH(CLADDR_WIDTH), .MDATA_WIDTH(MDATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic clear_in();
    bus.req_valid = '0;
    bus.req_is_wr = '0;
    bus.req_addr  = '0;
    bus.req_mdata = '0;
    bus.rsp_valid = '0;
    bus.rsp_mdata = '0;
  endtask

  task automatic drive_req(input int ch, input logic wr,
                           input logic [CLADDR_WIDTH-1:0] addr,
                           input logic [MDATA_WIDTH-1:0] md);
    bus.req_valid[ch] = 1'b1;
    bus.req_is_wr[ch] = wr;
    bus.req_addr[ch*CLADDR_WIDTH +: CLADDR_WIDTH] = addr;
    bus.req_mdata[ch*MDATA_WIDTH +: MDATA_WIDTH]  = md;
  endtask

  task automatic drive_rsp(input int ch, input logic [MDATA_WIDTH-1:0] md);
    bus.rsp_valid[ch] = 1'b1;
    bus.rsp_mdata[ch*MDATA_WIDTH +: MDATA_WIDTH] = md;
  endtask

  // Commit driven inputs on the next edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    exp_cnt = 0;
    resetb  = 1'b1;
    clear_in();
    #12;
    chk("rst_hv",   64'(bus.hazard_valid), 0);
    chk("rst_kind", 64'(bus.hazard_kind),  0);
    chk("rst_addr", 64'(bus.hazard_addr),  0);
    chk("rst_hcnt", 64'(bus.hazard_count), 0);
    chk("rst_ocnt", 64'(bus.orphan_count), 0);
    chk("rst_occ",  64'(bus.occupancy),    0);
    chk("rst_ovf",  64'(bus.overflow),     0);
    resetb = 1'b0;

    // WAR: read then write same line two cycles later
    drive_req(0, 1'b0, 32'h100, 14'd5);
    tick();
    chk("war_rd_hv",  64'(bus.hazard_valid), 0);
    chk("war_rd_occ", 64'(bus.occupancy),    1);
    tick();
    drive_req(1, 1'b1, 32'h100, 14'd6);
    tick();
    exp_cnt = 1;
    chk("war_hv",   64'(bus.hazard_valid), 1);
    chk("war_kind", 64'(bus.hazard_kind),  1);
    chk("war_addr", 64'(bus.hazard_addr),  64'h100);
    chk("war_cnt",  64'(bus.hazard_count), 64'(exp_cnt));
    chk("war_occ",  64'(bus.occupancy),    2);
    tick();
    chk("war_pulse",     64'(bus.hazard_valid), 0);
    chk("war_kind_hold", 64'(bus.hazard_kind),  1);
    chk("war_addr_hold", 64'(bus.hazard_addr),  64'h100);
    drive_rsp(0, 14'd5);
    drive_rsp(1, 14'd6);
    tick();
    chk("war_ret_occ", 64'(bus.occupancy),    0);
    chk("war_ret_orp", 64'(bus.orphan_count), 0);

    // Write, retire, read: no hazard
    drive_req(0, 1'b1, 32'h200, 14'd1);
    tick();
    chk("nohz_occ1", 64'(bus.occupancy), 1);
    drive_rsp(0, 14'd1);
    tick();
    chk("nohz_occ0", 64'(bus.occupancy), 0);
    drive_req(0, 1'b0, 32'h200, 14'd2);
    tick();
    chk("nohz_occ2", 64'(bus.occupancy),    1);
    chk("nohz_hv",   64'(bus.hazard_valid), 0);
    chk("nohz_cnt",  64'(bus.hazard_count), 64'(exp_cnt));
    drive_rsp(2, 14'd2);
    tick();
    chk("nohz_ret", 64'(bus.occupancy), 0);

    // Same-cycle writes on ch0 and ch1: WAW from ch1
    drive_req(0, 1'b1, 32'h300, 14'd10);
    drive_req(1, 1'b1, 32'h300, 14'd11);
    tick();
    exp_cnt = 2;
    chk("waw_hv",   64'(bus.hazard_valid), 1);
    chk("waw_kind", 64'(bus.hazard_kind),  2);
    chk("waw_addr", 64'(bus.hazard_addr),  64'h300);
    chk("waw_cnt",  64'(bus.hazard_count), 64'(exp_cnt));
    chk("waw_occ",  64'(bus.occupancy),    2);
    drive_rsp(0, 14'd10);
    drive_rsp(1, 14'd11);
    tick();
    chk("waw_ret", 64'(bus.occupancy), 0);

    // Read after read: reported only with the RAR build option
    drive_req(0, 1'b0, 32'h400, 14'd20);
    tick();
    drive_req(0, 1'b0, 32'h400, 14'd21);
    tick();
    exp_cnt = 2 + RAR_HITS;
    chk("rar_hv",  64'(bus.hazard_valid), 64'(RAR_HITS));
    chk("rar_cnt", 64'(bus.hazard_count), 64'(exp_cnt));
    chk("rar_kind", 64'(bus.hazard_kind), (RAR_HITS == 1) ? 64'd3 : 64'd2);
    drive_rsp(0, 14'd20);
    drive_rsp(1, 14'd21);
    tick();
    chk("rar_ret", 64'(bus.occupancy), 0);

    // Severity: read hits write (RAW); write then hits W and R -> WAW wins
    drive_req(0, 1'b1, 32'h500, 14'd30);
    tick();
    drive_req(0, 1'b0, 32'h500, 14'd31);
    tick();
    exp_cnt++;
    chk("raw_hv",   64'(bus.hazard_valid), 1);
    chk("raw_kind", 64'(bus.hazard_kind),  0);
    chk("raw_cnt",  64'(bus.hazard_count), 64'(exp_cnt));
    drive_req(1, 1'b1, 32'h500, 14'd32);
    tick();
    exp_cnt++;
    chk("sev_kind", 64'(bus.hazard_kind),  2);
    chk("sev_addr", 64'(bus.hazard_addr),  64'h500);
    chk("sev_cnt",  64'(bus.hazard_count), 64'(exp_cnt));
    chk("sev_occ",  64'(bus.occupancy),    3);
    drive_rsp(0, 14'd30);
    drive_rsp(1, 14'd31);
    drive_rsp(2, 14'd32);
    tick();
    chk("sev_ret", 64'(bus.occupancy), 0);

    // Retire and request to the same line in one cycle: no hazard
    drive_req(0, 1'b1, 32'h600, 14'd40);
    tick();
    drive_rsp(0, 14'd40);
    drive_req(0, 1'b0, 32'h600, 14'd41);
    tick();
    chk("same_edge_hv",  64'(bus.hazard_valid), 0);
    chk("same_edge_occ", 64'(bus.occupancy),    1);
    drive_rsp(0, 14'd41);
    tick();

    // Duplicate mdata: two responses claim two distinct entries
    drive_req(0, 1'b0, 32'h700, 14'd50);
    drive_req(1, 1'b0, 32'h704, 14'd50);
    tick();
    chk("dup_occ", 64'(bus.occupancy), 2);
    drive_rsp(0, 14'd50);
    drive_rsp(1, 14'd50);
    tick();
    chk("dup_ret", 64'(bus.occupancy),    0);
    chk("dup_orp", 64'(bus.orphan_count), 0);

    // Fill the table, then overflow
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      drive_req(0, 1'b0, 32'h1000 + 32'(i), 14'(100 + i));
      tick();
    end
    chk("full_occ", 64'(bus.occupancy), 16);
    chk("full_ovf", 64'(bus.overflow),  0);
    chk("full_hv",  64'(bus.hazard_count), 64'(exp_cnt));
    drive_req(0, 1'b0, 32'h1010, 14'd116);
    tick();
    chk("ovf_occ", 64'(bus.occupancy), 16);
    chk("ovf_set", 64'(bus.overflow),  1);
    // Dropped request still gets compared
    drive_req(0, 1'b1, 32'h1000, 14'd200);
    tick();
    exp_cnt++;
    chk("ovf_hz_hv",   64'(bus.hazard_valid), 1);
    chk("ovf_hz_kind", 64'(bus.hazard_kind),  1);
    chk("ovf_hz_addr", 64'(bus.hazard_addr),  64'h1000);
    chk("ovf_hz_cnt",  64'(bus.hazard_count), 64'(exp_cnt));
    chk("ovf_hz_occ",  64'(bus.occupancy),    16);
    // Orphan response
    drive_rsp(0, 14'd99);
    tick();
    chk("orp_cnt", 64'(bus.orphan_count), 1);
    chk("orp_occ", 64'(bus.occupancy),    16);
    // Retire down to 8 live entries
    drive_rsp(0, 14'd100); drive_rsp(1, 14'd101); drive_rsp(2, 14'd102);
    tick();
    drive_rsp(0, 14'd103); drive_rsp(1, 14'd104); drive_rsp(2, 14'd105);
    tick();
    drive_rsp(0, 14'd106); drive_rsp(1, 14'd107);
    tick();
    chk("drain_occ",  64'(bus.occupancy),    8);
    chk("drain_ovf",  64'(bus.overflow),     1);
    chk("drain_orp",  64'(bus.orphan_count), 1);

    // Asynchronous reset mid-traffic
    #2;
    resetb = 1'b1;
    #1;
    chk("arst_hv",   64'(bus.hazard_valid), 0);
    chk("arst_kind", 64'(bus.hazard_kind),  0);
    chk("arst_addr", 64'(bus.hazard_addr),  0);
    chk("arst_hcnt", 64'(bus.hazard_count), 0);
    chk("arst_ocnt", 64'(bus.orphan_count), 0);
    chk("arst_occ",  64'(bus.occupancy),    0);
    chk("arst_ovf",  64'(bus.overflow),     0);
    #1;
    resetb = 1'b0;
    drive_rsp(0, 14'd110);
    tick();
    chk("post_rst_orp", 64'(bus.orphan_count), 1);
    chk("post_rst_occ", 64'(bus.occupancy),    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
